// File: rtl/idc_pkg.sv
// Shared types and constants for the ID check-digit stream validator.
package idc_pkg;

    typedef enum logic {
        MODE_NATIONAL = 1'b0,
        MODE_LUHN     = 1'b1
    } mode_e;

    typedef enum logic {
        StIdle    = 1'b0,
        StCollect = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic legal;
        logic abort;
    } result_t;

    localparam logic [5:0] LETTER_MIN = 6'd10;
    localparam logic [5:0] LETTER_MAX = 6'd35;
    localparam logic [5:0] DIGIT_MAX  = 6'd9;

    // Positions 0..15 cover the largest legal NUM_DIGITS of 16.
    localparam int unsigned POS_W = 4;

    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
    endfunction

endpackage

// File: rtl/idc_weight_lut.sv
// Per-symbol weighted contribution (mod 10) and range check for both checksum schemes.
module idc_weight_lut
    import idc_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 10
) (
    input  mode_e            mode_i,
    input  logic [POS_W-1:0] pos_i,
    input  logic [5:0]       sym_i,
    output logic [3:0]       contrib_o,
    output logic             err_o
);

    logic [3:0] sym_lo;
    logic [3:0] sym_hi;
    logic [3:0] rdist;
    logic [3:0] weight;
    logic [7:0] raw;

    always_comb begin
        sym_lo = 4'(sym_i % 6'd10);
        sym_hi = 4'(sym_i / 6'd10);
        rdist  = POS_W'(NUM_DIGITS - 1) - pos_i;
        // The check digit carries weight 1 rather than its zero distance.
        weight = (rdist == 4'd0) ? 4'd1 : rdist;
        raw    = 8'd0;
        err_o  = 1'b0;
        if (mode_i == MODE_NATIONAL) begin
            if (pos_i == '0) begin
                err_o = (sym_i < LETTER_MIN) || (sym_i > LETTER_MAX);
                raw   = {4'd0, sym_hi} + 8'(sym_lo) * 8'd9;
            end else begin
                err_o = sym_i > DIGIT_MAX;
                raw   = 8'(sym_lo) * 8'(weight);
            end
        end else begin
            err_o = sym_i > DIGIT_MAX;
            if (rdist[0]) begin
                raw = (sym_lo > 4'd4) ? 8'(sym_lo) * 8'd2 - 8'd9 : 8'(sym_lo) * 8'd2;
            end else begin
                raw = 8'(sym_lo);
            end
        end
    end

    assign contrib_o = 4'(raw % 8'd10);

endmodule

// File: rtl/idc_stream.sv
// Streaming ID validator: accumulates a mod-10 weighted checksum one symbol per cycle
// and emits a legal/abort result three edges after the closing symbol.
module idc_stream
    import idc_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 10,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [5:0]       in_id,
    output logic             out_valid,
    output logic             out_legal_id,
    output logic             out_abort,
    output logic [CNT_W-1:0] legal_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             busy
);

    localparam logic [POS_W-1:0] LastPos = POS_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, cur_mode;
    logic [POS_W-1:0] pos_q, pos_d, cur_pos;
    logic [3:0]       acc_q, acc_d, acc_sum, contrib;
    logic             err_q, err_d, err_sum, lut_err;
    logic             in_idle, last_sym, abort_id;
    result_t          res_d, s1_q, s2_q, out_q;
    logic [CNT_W-1:0] legal_cnt_q, legal_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    idc_weight_lut #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_weight_lut (
        .mode_i    (cur_mode),
        .pos_i     (cur_pos),
        .sym_i     (in_id),
        .contrib_o (contrib),
        .err_o     (lut_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (in_valid) state_d = StCollect;
            StCollect: if (!in_valid || last_sym) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StCollect);
    end

    // Symbol 0 is scored in IDLE, so its mode and position come straight from the inputs.
    always_comb begin
        in_idle  = (state_q == StIdle);
        cur_pos  = in_idle ? '0 : pos_q;
        cur_mode = in_idle ? mode_e'(in_mode) : mode_q;
        acc_sum  = add_mod10(in_idle ? 4'd0 : acc_q, contrib);
        err_sum  = lut_err | (~in_idle & err_q);
        last_sym = ~in_idle & in_valid & (pos_q == LastPos);
        abort_id = ~in_idle & ~in_valid;
        mode_d   = (in_idle && in_valid) ? cur_mode : mode_q;

        if (in_valid && !last_sym) begin
            pos_d = cur_pos + POS_W'(1);
            acc_d = acc_sum;
            err_d = err_sum;
        end else begin
            pos_d = '0;
            acc_d = 4'd0;
            err_d = 1'b0;
        end

        res_d.valid = last_sym | abort_id;
        res_d.legal = last_sym & (acc_sum == 4'd0) & ~err_sum;
        res_d.abort = abort_id;
    end

    always_comb begin
        legal_cnt_d   = legal_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (s2_q.valid && !s2_q.abort) begin
            if (s2_q.legal) begin
                if (legal_cnt_q != CntMax) legal_cnt_d = legal_cnt_q + CNT_W'(1);
            end else begin
                if (illegal_cnt_q != CntMax) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counters advance on the same edge that raises out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_NATIONAL;
            pos_q         <= '0;
            acc_q         <= 4'd0;
            err_q         <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            out_q         <= '0;
            legal_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            mode_q        <= mode_d;
            pos_q         <= pos_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            s1_q          <= res_d;
            s2_q          <= s1_q;
            out_q         <= s2_q;
            legal_cnt_q   <= legal_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid    = out_q.valid;
    assign out_legal_id = out_q.legal;
    assign out_abort    = out_q.abort;
    assign legal_cnt    = legal_cnt_q;
    assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_idc_stream.sv
// Self-checking bench for idc_stream: directed IDs plus random streams against a
// wide-sum reference model and a due-cycle result scoreboard.
module tb_idc_stream;

    localparam int N = 10;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_mode  = 1'b0;
    logic [5:0] in_id    = 6'd0;

    logic       out_valid, out_legal_id, out_abort, busy;
    logic [7:0] legal_cnt, illegal_cnt;
    logic       ov_b, ol_b, oa_b, busy_b;
    logic [1:0] lc_b, ic_b;

    typedef struct {
        int due;
        bit legal;
        bit abort;
    } exp_t;

    exp_t exp_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   exp_legal   = 0;
    int   exp_illegal = 0;
    bit   pop_prev    = 1'b0;
    bit   pop_now;
    exp_t mon_r;

    idc_stream #(
        .NUM_DIGITS (N),
        .CNT_W      (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mode      (in_mode),
        .in_id        (in_id),
        .out_valid    (out_valid),
        .out_legal_id (out_legal_id),
        .out_abort    (out_abort),
        .legal_cnt    (legal_cnt),
        .illegal_cnt  (illegal_cnt),
        .busy         (busy)
    );

    idc_stream #(
        .NUM_DIGITS (N),
        .CNT_W      (2)
    ) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mode      (in_mode),
        .in_id        (in_id),
        .out_valid    (ov_b),
        .out_legal_id (ol_b),
        .out_abort    (oa_b),
        .legal_cnt    (lc_b),
        .illegal_cnt  (ic_b),
        .busy         (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Full weighted sum straight from the scheme definitions, reduced only at the end.
    function automatic int ref_sum(input bit m, input int s[16], output bit err);
        int sum;
        int d;
        int r;
        sum = 0;
        err = 1'b0;
        for (int k = 0; k < N; k++) begin
            d = s[k];
            r = N - 1 - k;
            if (!m) begin
                if (k == 0) begin
                    if (d < 10 || d > 35) err = 1'b1;
                    sum += (d / 10) + (d % 10) * 9;
                end else begin
                    if (d > 9) err = 1'b1;
                    sum += d * ((k == N - 1) ? 1 : r);
                end
            end else begin
                if (d > 9) err = 1'b1;
                if (r % 2 == 0) sum += d;
                else sum += (2 * d > 9) ? 2 * d - 9 : 2 * d;
            end
        end
        return sum;
    endfunction

    always @(negedge clk) begin
        pop_now = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_r   = exp_q.pop_front();
            pop_now = 1'b1;
            check_eq("out_valid", out_valid, 1);
            check_eq("out_legal_id", out_legal_id, mon_r.legal);
            check_eq("out_abort", out_abort, mon_r.abort);
            check_eq("sat_out_valid", {ov_b, ol_b, oa_b}, {1'b1, mon_r.legal, mon_r.abort});
            if (!mon_r.abort) begin
                if (mon_r.legal) exp_legal++;
                else exp_illegal++;
            end
        end else begin
            check_eq("quiet_outputs", {out_valid, out_legal_id, out_abort}, 0);
            check_eq("sat_quiet_outputs", {ov_b, ol_b, oa_b}, 0);
        end
        if (rst) begin
            exp_legal   = 0;
            exp_illegal = 0;
        end else if (!pop_now && !pop_prev) begin
            check_eq("legal_cnt", legal_cnt, sat(exp_legal, 255));
            check_eq("illegal_cnt", illegal_cnt, sat(exp_illegal, 255));
            check_eq("sat_legal_cnt", lc_b, sat(exp_legal, 3));
            check_eq("sat_illegal_cnt", ic_b, sat(exp_illegal, 3));
        end
        pop_prev = pop_now;
    end

    task automatic drive_sym(input bit v, input bit m, input int sym, input bit want_busy);
        in_valid = v;
        in_mode  = m;
        in_id    = 6'(sym);
        @(posedge clk);
        #1;
        check_eq("busy", busy, want_busy);
        check_eq("sat_busy", busy_b, want_busy);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_sym(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'b0);
    endtask

    // Sends symbols 0..stop_at-1; a full ID when stop_at >= N.
    task automatic send_id(input bit m, input int s[16], input int stop_at, input bit do_abort);
        exp_t e;
        int   sum;
        bit   err;
        for (int k = 0; k < N; k++) begin
            if (k == stop_at) begin
                if (do_abort) begin
                    drive_sym(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'b0);
                    e.due   = cyc + 2;
                    e.legal = 1'b0;
                    e.abort = 1'b1;
                    exp_q.push_back(e);
                end
                return;
            end
            drive_sym(1'b1, (k == 0) ? m : 1'($urandom_range(0, 1)), s[k], k != N - 1);
        end
        sum     = ref_sum(m, s, err);
        e.due   = cyc + 2;
        e.legal = !err && (sum % 10 == 0);
        e.abort = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].due > cyc) begin
            exp_q.delete(exp_q.size() - 1);
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_flags", {out_legal_id, out_abort}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_legal_cnt", legal_cnt, 0);
        check_eq("rst_illegal_cnt", illegal_cnt, 0);
    endtask

    task automatic gen_id(output bit m, output int s[16]);
        int sum;
        bit err;
        int pick;
        int k;
        m = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) s[i] = (i < N) ? int'($urandom_range(0, 9)) : 0;
        if (!m) s[0] = $urandom_range(10, 35);
        pick = $urandom_range(0, 7);
        if (pick < 4) begin
            s[N - 1] = 0;
            sum      = ref_sum(m, s, err);
            s[N - 1] = (10 - sum % 10) % 10;
        end
        if (pick == 7) begin
            k = $urandom_range(0, N - 1);
            if (!m && k == 0) begin
                s[0] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9))
                                                    : int'($urandom_range(36, 63));
            end else begin
                s[k] = $urandom_range(10, 63);
            end
        end
    endtask

    initial begin
        int s_nat[16];
        int s_luhn[16];
        int s[16];
        bit m;

        s_nat  = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0};
        s_luhn = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 7, 0, 0, 0, 0, 0, 0};

        do_reset(3);

        send_id(1'b0, s_nat, N, 1'b0);
        idle(4);
        check_eq("dir_nat_legal_cnt", legal_cnt, 1);

        s = s_nat;
        s[9] = 8;
        send_id(1'b0, s, N, 1'b0);
        s = s_nat;
        s[0] = 36;
        send_id(1'b0, s, N, 1'b0);
        idle(4);
        check_eq("dir_nat_illegal_cnt", illegal_cnt, 2);

        send_id(1'b1, s_luhn, N, 1'b0);
        s = s_luhn;
        s[9] = 6;
        send_id(1'b1, s, N, 1'b0);
        idle(4);
        check_eq("dir_luhn_legal_cnt", legal_cnt, 2);
        check_eq("dir_luhn_illegal_cnt", illegal_cnt, 3);

        send_id(1'b0, s_nat, N, 1'b0);
        send_id(1'b0, s_nat, N, 1'b0);
        idle(4);
        check_eq("dir_b2b_legal_cnt", legal_cnt, 4);

        send_id(1'b0, s_nat, 4, 1'b1);
        idle(4);
        check_eq("dir_abort_legal_cnt", legal_cnt, 4);
        check_eq("dir_abort_illegal_cnt", illegal_cnt, 3);

        send_id(1'b0, s_nat, 5, 1'b0);
        do_reset(2);
        idle(3);
        send_id(1'b1, s_luhn, N, 1'b0);
        do_reset(1);
        idle(4);

        repeat (60) begin
            gen_id(m, s);
            if ($urandom_range(0, 9) == 0) send_id(m, s, $urandom_range(1, N - 1), 1'b1);
            else send_id(m, s, N, 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

        do_reset(2);
        repeat (5) send_id(1'b1, s_luhn, N, 1'b0);
        idle(5);
        check_eq("sat5_legal_cnt", legal_cnt, 5);
        check_eq("sat5_legal_cnt_w2", lc_b, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idc_stream.md
IDC_STREAM -- requirements
Module: idc_stream

Interface
REQ-001 Parameter NUM_DIGITS, default 10, symbols per ID including the check digit; legal range 3..16.
REQ-002 Parameter CNT_W, default 8, width of the result counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  high while the current symbol is valid; one symbol per cycle.
REQ-006 in_mode  input  1  checksum scheme: 0 = national ID (letter-code first symbol), 1 = Luhn mod-10; sampled with the first symbol only.
REQ-007 in_id  input  6  current symbol: letter code 10..35 or digit 0..9.
REQ-008 out_valid  output  1  one-cycle result strobe.
REQ-009 out_legal_id  output  1  1 = ID legal; qualified by out_valid.
REQ-010 out_abort  output  1  1 = ID was truncated; qualified by out_valid.
REQ-011 legal_cnt  output  CNT_W  saturating count of legal IDs.
REQ-012 illegal_cnt  output  CNT_W  saturating count of illegal, non-aborted IDs.
REQ-013 busy  output  1  high while the FSM is in COLLECT.

Function
REQ-014 The FSM SHALL have two states:
- IDLE: in_valid=1 accepts symbol 0, latches in_mode, and moves to COLLECT with position=1.
- COLLECT: each cycle with in_valid=1 accepts the next symbol; the symbol at position NUM_DIGITS-1 returns the FSM to IDLE.
REQ-015 The accumulator SHALL hold the running weighted sum reduced mod 10 (4 bits) after every accepted symbol; no wide sum is stored.
REQ-016 Mode 0 SHALL add:
- symbol 0 code L: (L/10)*1 + (L%10)*9;
- symbol k, 1..NUM_DIGITS-2: d*(NUM_DIGITS-1-k);
- last symbol: d*1.
REQ-017 Mode 0 SHALL flag a range error if symbol 0 is outside 10..35 or any later symbol is >9.
REQ-018 Mode 1 SHALL add, for the symbol at distance r=NUM_DIGITS-1-k from the right: d if r is even, else 2d-9 if 2d>9, else 2d.
REQ-019 Mode 1 SHALL flag a range error if any symbol is >9.
REQ-020 An ID SHALL be legal iff the final sum mod 10 == 0 and no range error occurred.
REQ-021 Result latency: if the last symbol is sampled at edge T, out_valid SHALL be 1 for exactly the cycle after edge T+2.
REQ-022 Back-to-back: a new ID MAY begin in the cycle immediately after the previous last symbol; results SHALL emerge in order without loss.
REQ-023 in_valid=0 while in COLLECT SHALL abort the ID:
- FSM returns to IDLE and the partial sum is discarded;
- if that edge is T, out_valid=1, out_abort=1 and out_legal_id=0 for the cycle after edge T+2.
REQ-024 out_legal_id and out_abort SHALL be 0 whenever out_valid=0.
REQ-025 Counters SHALL update on the out_valid cycle:
- legal result increments legal_cnt;
- illegal, non-aborted result increments illegal_cnt;
- aborted result increments neither;
- each counter saturates at 2^CNT_W-1.
REQ-026 in_mode changes while in COLLECT SHALL be ignored.

Reset
REQ-027 While rst=1 at an edge, the block SHALL:
- set the FSM to IDLE;
- set position, accumulator and error flag to 0;
- set out_valid, out_legal_id, out_abort, legal_cnt, illegal_cnt and busy to 0;
- flush results in flight.
REQ-028 Reset SHALL override simultaneous symbol acceptance and counter increments; the first symbol is accepted at the first edge with rst=0.

Structure
REQ-029 Package idc_pkg SHALL hold:
- the mode enum (MODE_NATIONAL, MODE_LUHN);
- the FSM state enum;
- the constants LETTER_MIN=10, LETTER_MAX=35, DIGIT_MAX=9.
REQ-030 Sub-module idc_weight_lut SHALL be combinational: (mode, position, symbol, NUM_DIGITS) -> 4-bit contribution mod 10 plus range-error bit.

Verification
REQ-031 Mode 0, symbols 10,1,2,3,4,5,6,7,8,9 ("A123456789") -> out_valid 2 cycles after the last symbol, out_legal_id=1, legal_cnt=1.
REQ-032 Mode 0, symbols 10,1,2,3,4,5,6,7,8,8 -> out_legal_id=0, illegal_cnt=1; symbol 0 = 36 with a valid tail -> out_legal_id=0.
REQ-033 Mode 1, digits 1,2,3,4,5,6,7,8,9,7 -> legal; with last digit 6 -> illegal.
REQ-034 Two back-to-back legal IDs with no gap -> two out_valid pulses exactly 10 cycles apart, legal_cnt=2.
REQ-035 in_valid drops after 4 symbols -> out_abort=1, out_legal_id=0, counters unchanged; rst asserted mid-ID -> no out_valid and all outputs 0.
REQ-036 CNT_W=2, 5 legal IDs -> legal_cnt saturates at 3.
